// File: rtl/scatter_pkg.sv
// Shared types and the tile-row address helper for the B-operand ping-pong scatter.
package scatter_pkg;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchRun,
    FetchDrain
  } fetch_state_t;

  typedef enum logic [1:0] {
    StreamIdle,
    StreamWait,
    StreamRun
  } stream_state_t;

  typedef logic bank_idx_t;

  // Word address of row k of tile (r, c); caller truncates to the BRAM address width.
  function automatic logic [31:0] addr_of(input logic [31:0] base, input logic [31:0] r,
                                          input logic [31:0] k, input logic [31:0] tiles_x,
                                          input logic [31:0] c, input int unsigned n);
    return base + (r * n + k) * tiles_x + c;
  endfunction

endpackage

// File: rtl/scatter_tile_bank.sv
// One N x N tile buffer: whole-row writes, row- or column-wide reads.
module scatter_tile_bank #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 16,
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [CW-1:0] wrow_i,
  input  logic [N*W-1:0] wdata_i,
  input  logic [CW-1:0] sel_i,
  input  logic          transpose_i,
  output logic [N*W-1:0] rdata_o
);

  logic [W-1:0] mem_q [N][N];

  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < N; i++) begin
        mem_q[wrow_i][i] <= wdata_i[W*i +: W];
      end
    end
  end

  // Normal mode returns column sel_i (one element per row); transpose returns row sel_i.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N; i++) begin
      rdata_o[W*i +: W] = transpose_i ? mem_q[sel_i][i] : mem_q[i][sel_i];
    end
  end

endmodule

// File: rtl/scatter_b_pingpong.sv
// B-operand scatter: prefetches N x N tiles from BRAM into two banks and streams one bank
// into the systolic array a column per cycle while the other bank refills.
module scatter_b_pingpong
  import scatter_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned N         = 16,
  parameter int unsigned BRAM_W    = 128,
  parameter int unsigned BRAM_AW   = 10,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_TILES = 16,
  localparam int unsigned TW = $clog2(MAX_TILES) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BRAM_AW-1:0] cfg_base,
  input  logic [TW-1:0]      cfg_tiles_x,
  input  logic [TW-1:0]      cfg_tiles_y,
  input  logic               cfg_transpose,
  input  logic               tile_req,
  output logic               bram_clk_b,
  output logic               bram_en_b,
  output logic               bram_we_b,
  output logic [BRAM_AW-1:0] bram_addr_b,
  input  logic [BRAM_W-1:0]  bram_rddata_b,
  output logic [N*W-1:0]     b_ins,
  output logic               b_valid,
  output logic               stationaryCtrl,
  output logic               tile_done,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  fetch_state_t  fetch_q, fetch_d;
  stream_state_t stream_q, stream_d;

  logic [BRAM_AW-1:0] base_q;
  logic [TW-1:0]      tiles_x_q, tiles_y_q;
  logic               transpose_q;

  logic [CW-1:0] k_q, k_d;
  logic [1:0]    drain_q, drain_d;
  logic [TW-1:0] fr_q, fr_d, fc_q, fc_d;
  bank_idx_t     fbank_q, fbank_d;
  logic [1:0]    full_q, full_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] sr_q, sr_d, sc_q, sc_d;
  bank_idx_t     sbank_q, sbank_d;
  logic          first_q, first_d;
  logic          req_pend_q, req_pend_d;
  logic          done_q, done_d;

  logic [RD_LAT-1:0]         vld_pipe_q;
  logic [RD_LAT-1:0][CW-1:0] row_pipe_q;
  logic [RD_LAT-1:0]         bank_pipe_q;

  logic           start_ok, zero_job;
  logic           fetch_en, fetch_last_tile, fill_done;
  logic [1:0]     rdy;
  logic           req_now, tile_done_c, stream_last_tile, consume;
  logic           wr_en, wr_bank;
  logic [CW-1:0]  wr_row;
  logic [N*W-1:0] rd0, rd1;

  assign start_ok = start && (stream_q == StreamIdle);
  assign zero_job = (cfg_tiles_x == '0) || (cfg_tiles_y == '0);

  // Fetch only ever stalls at row 0: the target bank is full until its tile is streamed.
  assign fetch_en        = (fetch_q == FetchRun) && !full_q[fbank_q];
  assign fill_done       = (fetch_q == FetchDrain) && (drain_q == 2'(RD_LAT - 1));
  assign fetch_last_tile = (fr_q == tiles_y_q - TW'(1)) && (fc_q == tiles_x_q - TW'(1));

  // Look ahead on the drain's final cycle so streaming can begin without a bubble.
  assign rdy[0] = full_q[0] | (fill_done && (fbank_q == 1'b0));
  assign rdy[1] = full_q[1] | (fill_done && (fbank_q == 1'b1));

  assign req_now          = req_pend_q | tile_req;
  assign tile_done_c      = (stream_q == StreamRun) && (cnt_q == CW'(N - 1));
  assign stream_last_tile = (sr_q == tiles_y_q - TW'(1)) && (sc_q == tiles_x_q - TW'(1));

  assign wr_en   = vld_pipe_q[RD_LAT-1];
  assign wr_row  = row_pipe_q[RD_LAT-1];
  assign wr_bank = bank_pipe_q[RD_LAT-1];

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q  <= FetchIdle;
      stream_q <= StreamIdle;
    end else begin
      fetch_q  <= fetch_d;
      stream_q <= stream_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    fetch_d = fetch_q;
    unique case (fetch_q)
      FetchIdle:  if (start_ok && !zero_job) fetch_d = FetchRun;
      FetchRun:   if (fetch_en && (k_q == CW'(N - 1))) fetch_d = FetchDrain;
      FetchDrain: if (fill_done) fetch_d = fetch_last_tile ? FetchIdle : FetchRun;
      default:    fetch_d = FetchIdle;
    endcase
  end

  always_comb begin
    stream_d = stream_q;
    unique case (stream_q)
      StreamIdle: if (start_ok && !zero_job) stream_d = StreamWait;
      StreamWait: if (rdy[sbank_q] && (first_q || req_now)) stream_d = StreamRun;
      StreamRun: begin
        if (tile_done_c) begin
          if (stream_last_tile)            stream_d = StreamIdle;
          else if (req_now && rdy[~sbank_q]) stream_d = StreamRun;
          else                             stream_d = StreamWait;
        end
      end
      default: stream_d = StreamIdle;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bram_clk_b     = clk;
    bram_en_b      = fetch_en;
    bram_we_b      = 1'b0;
    bram_addr_b    = '0;
    if (fetch_en) begin
      bram_addr_b = BRAM_AW'(addr_of(32'(base_q), 32'(fr_q), 32'(k_q), 32'(tiles_x_q),
                                     32'(fc_q), N));
    end
    b_valid        = (stream_q == StreamRun);
    stationaryCtrl = b_valid;
    b_ins          = '0;
    if (b_valid) b_ins = sbank_q ? rd1 : rd0;
    tile_done      = tile_done_c;
    busy           = (stream_q != StreamIdle);
    done           = done_q;
  end

  // ---------------- fetch datapath ----------------
  always_comb begin
    k_d     = k_q;
    drain_d = drain_q;
    fr_d    = fr_q;
    fc_d    = fc_q;
    fbank_d = fbank_q;
    if (start_ok) begin
      k_d     = '0;
      drain_d = '0;
      fr_d    = '0;
      fc_d    = '0;
      fbank_d = 1'b0;
    end else begin
      if (fetch_en) k_d = (k_q == CW'(N - 1)) ? '0 : k_q + CW'(1);
      if (fetch_q == FetchDrain) drain_d = fill_done ? 2'd0 : drain_q + 2'd1;
      if (fill_done) begin
        fbank_d = ~fbank_q;
        if (fr_q == tiles_y_q - TW'(1)) begin
          fr_d = '0;
          fc_d = fc_q + TW'(1);
        end else begin
          fr_d = fr_q + TW'(1);
        end
      end
    end
  end

  // ---------------- stream datapath ----------------
  assign consume = ((stream_q == StreamWait) && (stream_d == StreamRun) && !first_q) ||
                   ((stream_q == StreamRun) && (stream_d == StreamRun) && tile_done_c);

  always_comb begin
    cnt_d      = cnt_q;
    sbank_d    = sbank_q;
    sr_d       = sr_q;
    sc_d       = sc_q;
    first_d    = first_q;
    req_pend_d = req_pend_q;
    full_d     = full_q;
    if (start_ok) begin
      cnt_d      = '0;
      sbank_d    = 1'b0;
      sr_d       = '0;
      sc_d       = '0;
      first_d    = 1'b1;
      req_pend_d = 1'b0;
      full_d     = '0;
    end else begin
      if (stream_q == StreamRun) begin
        if (tile_done_c) begin
          cnt_d   = '0;
          sbank_d = ~sbank_q;
          if (sr_q == tiles_y_q - TW'(1)) begin
            sr_d = '0;
            sc_d = sc_q + TW'(1);
          end else begin
            sr_d = sr_q + TW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if ((stream_q == StreamWait) && (stream_d == StreamRun)) first_d = 1'b0;
      // A single outstanding request is remembered; repeats while one is pending are lost.
      if (consume)                                    req_pend_d = 1'b0;
      else if (tile_req && (stream_q != StreamIdle)) req_pend_d = 1'b1;
      if (fill_done)   full_d[fbank_q] = 1'b1;
      if (tile_done_c) full_d[sbank_q] = 1'b0;
    end
  end

  assign done_d = (start_ok && zero_job) || (tile_done_c && stream_last_tile);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      tiles_x_q   <= '0;
      tiles_y_q   <= '0;
      transpose_q <= 1'b0;
      k_q         <= '0;
      drain_q     <= '0;
      fr_q        <= '0;
      fc_q        <= '0;
      fbank_q     <= 1'b0;
      full_q      <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      sc_q        <= '0;
      sbank_q     <= 1'b0;
      first_q     <= 1'b0;
      req_pend_q  <= 1'b0;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      row_pipe_q  <= '0;
      bank_pipe_q <= '0;
    end else begin
      if (start_ok) begin
        base_q      <= cfg_base;
        tiles_x_q   <= cfg_tiles_x;
        tiles_y_q   <= cfg_tiles_y;
        transpose_q <= cfg_transpose;
      end
      k_q        <= k_d;
      drain_q    <= drain_d;
      fr_q       <= fr_d;
      fc_q       <= fc_d;
      fbank_q    <= fbank_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      sc_q       <= sc_d;
      sbank_q    <= sbank_d;
      first_q    <= first_d;
      req_pend_q <= req_pend_d;
      done_q     <= done_d;
      // Carries each read's row/bank alongside the BRAM latency.
      vld_pipe_q[0]  <= fetch_en;
      row_pipe_q[0]  <= k_q;
      bank_pipe_q[0] <= fbank_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        row_pipe_q[i]  <= row_pipe_q[i-1];
        bank_pipe_q[i] <= bank_pipe_q[i-1];
      end
    end
  end

  scatter_tile_bank #(
    .W(W),
    .N(N)
  ) u_bank0 (
    .clk_i      (clk),
    .we_i       (wr_en && (wr_bank == 1'b0)),
    .wrow_i     (wr_row),
    .wdata_i    (bram_rddata_b),
    .sel_i      (cnt_q),
    .transpose_i(transpose_q),
    .rdata_o    (rd0)
  );

  scatter_tile_bank #(
    .W(W),
    .N(N)
  ) u_bank1 (
    .clk_i      (clk),
    .we_i       (wr_en && (wr_bank == 1'b1)),
    .wrow_i     (wr_row),
    .wdata_i    (bram_rddata_b),
    .sel_i      (cnt_q),
    .transpose_i(transpose_q),
    .rdata_o    (rd1)
  );

endmodule
